// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus arbiter.
//   arb_state_e            - arbiter FSM encoding (IDLE=0, BUSY=1, RELEASE=2)
//   DEFAULT_TIMEOUT_CYCLES - default watchdog limit in BUSY cycles
//   rr_index()             - round-robin candidate index helper
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Index of the off-th candidate after 'last', wrapping at n-1 back to 0.
  // Callers guarantee last < n and off < n, so a single subtraction wraps.
  function automatic int unsigned rr_index(input int unsigned last,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = last + off + 1;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   req    in  NUM_MASTERS  request vector
//   last   in  ID_W         previous winner; search starts at last+1
//   found  out 1            any request present
//   winner out ID_W         first requesting index at or after last+1 (wrapping)
module rr_picker
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        last,
  output logic                   found,
  output logic [ID_W-1:0]        winner
);

  // cand_hit[k] : the master k positions after 'last' (+1) is requesting.
  logic [NUM_MASTERS-1:0] cand_hit;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
    assign cand_hit[gi] = req[ID_W'(rr_index(32'(last), gi, NUM_MASTERS))];
  end

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    found  = |cand_hit;
    winner = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        winner = ID_W'(rr_index(32'(last), i, NUM_MASTERS));
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the shared serial bus.
// One master is granted at a time; the grant is held until 'done' or until
// the owner drops its request, followed by one turnaround cycle (RELEASE).
// Optional watchdog: define ARB_TIMEOUT_EN to build the BUSY-cycle counter
// that forces a release after TIMEOUT_CYCLES cycles and pulses 'timeout'.
// Ports:
//   clk       in  1            rising-edge clock
//   reset     in  1            synchronous, active-high
//   req       in  NUM_MASTERS  per-master request, held for the transaction
//   done      in  1            transaction-complete pulse (tx_done | rx_done)
//   grant     out NUM_MASTERS  one-hot grant, zero when nobody owns the bus
//   grant_id  out ID_W         index of the owner; holds when grant is zero
//   bus_busy  out 1            a grant is active
//   timeout   out 1            one-cycle pulse on a watchdog release
// All outputs are registered.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int ID_W           = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   bus_busy,
  output logic                   timeout
);

  if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 2 || ID_W < 1) begin : g_param_check
    $error("bus_arbiter: NUM_MASTERS and TIMEOUT_CYCLES must be at least 2");
  end

  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic                   bus_busy_q, bus_busy_d;
  logic                   timeout_q, timeout_d;

  logic                   pick_found;
  logic [ID_W-1:0]        pick_id;
  logic                   wd_expire;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_W        (ID_W)
  ) u_picker (
    .req    (req),
    .last   (last_q),
    .found  (pick_found),
    .winner (pick_id)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Counter is zero whenever the bus is not BUSY, so it starts from zero on
  // every BUSY entry and counts completed BUSY cycles.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == ST_BUSY) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign wd_expire = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    bus_busy_d = bus_busy_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d          = ST_BUSY;
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          grant_id_d       = pick_id;
          last_d           = pick_id;
          bus_busy_d       = 1'b1;
        end
      end

      ST_BUSY: begin
        // Normal completion (done or abandon) takes precedence over the
        // watchdog, so a coincident done never reports a timeout.
        if (done || !req[grant_id_q]) begin
          state_d    = ST_RELEASE;
          grant_d    = '0;
          bus_busy_d = 1'b0;
        end else if (wd_expire) begin
          state_d    = ST_RELEASE;
          grant_d    = '0;
          bus_busy_d = 1'b0;
          timeout_d  = 1'b1;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        bus_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_RESET;
      grant_q    <= '0;
      grant_id_q <= '0;
      bus_busy_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      bus_busy_q <= bus_busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign bus_busy = bus_busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter (NUM_MASTERS=4, TIMEOUT_CYCLES=8).
// Stimulus pushes the expected (master, cycle) of every grant into a queue;
// a negedge monitor pops and compares when a new grant appears.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          done  = 1'b0;
  logic [N-1:0]  req   = '0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          bus_busy;
  logic          timeout;

  bus_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (TO),
    .ID_W           (IW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           checks     = 0;
  int           failures   = 0;
  int           tout_seen  = 0;
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_exp(input int id, input int c);
    exp_t e;
    e.id  = id;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // One transaction from IDLE: request r, expect master id granted next
  // cycle, hold len BUSY cycles, then end it.
  // mode 0: done pulse; 1: request dropped; 2: both together.
  task automatic txn(input logic [N-1:0] r, input int id, input int len, input int mode);
    int k;
    k   = cyc;
    req = r;
    push_exp(id, k + 1);
    goto_cyc(k + len);
    if (mode != 1) done = 1'b1;
    if (mode != 0) req = '0;
    step();
    done = 1'b0;
    req  = '0;
    check("release_grant", grant, 0);
    check("release_busy", bus_busy, 0);
    check("release_timeout", timeout, 0);
    check("hold_grant_id", grant_id, id);
    goto_cyc(k + len + 2);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    check("busy_vs_grant", bus_busy, (grant != '0) ? 1 : 0);
    if (grant != '0 && prev_grant == '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got grant=%b expected none at cycle %0d", grant, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("grant master %0d at cycle %0d (expected master %0d at cycle %0d)",
                 grant_id, cyc, e.id, e.cyc);
        check("grant_id", grant_id, e.id);
        check("grant_onehot", grant, 1 << e.id);
        check("grant_cycle", cyc, e.cyc);
      end
    end else if (grant != '0 && grant != prev_grant) begin
      checks++;
      failures++;
      $display("FAIL grant_changed: got %b expected %b at cycle %0d", grant, prev_grant, cyc);
    end
    if (timeout) begin
      tout_seen++;
      check("timeout_grant_clear", grant, 0);
    end
    prev_grant <= grant;
  end

  initial begin : stim
    int k;
    int g;

    // Reset state
    repeat (3) step();
    check("rst_grant", grant, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    step();

    // Single request, pointer from reset gives master 0
    txn(4'b0001, 0, 5, 0);

    // Fairness: all requesting, done in the 4th BUSY cycle of each grant.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    k   = cyc;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(i % N, k + 1 + 6 * i);
    for (int i = 0; i < 5; i++) begin
      g = k + 1 + 6 * i;
      goto_cyc(g + 3);
      done = 1'b1;
      step();
      done = 1'b0;
      if (i == 4) req = '0;
    end
    goto_cyc(cyc + 1);

    // Wrap and skip: pointer to 2, then 0011 wins 0, then 1
    txn(4'b0100, 2, 2, 0);
    txn(4'b0011, 0, 2, 0);
    txn(4'b0011, 1, 2, 0);

    // Abandon, and done together with a dropped request
    txn(4'b0010, 1, 3, 1);
    txn(4'b0001, 0, 2, 2);

    // done on the watchdog-expiry cycle counts as normal completion
    txn(4'b0010, 1, TO, 0);

    // Watchdog: done never arrives
    k   = cyc;
    req = 4'b0100;
    push_exp(2, k + 1);
    goto_cyc(k + TO);
    check("wd_pre_grant", grant, 4'b0100);
    check("wd_pre_timeout", timeout, 0);
    step();
`ifdef ARB_TIMEOUT_EN
    check("wd_fire_grant", grant, 0);
    check("wd_fire_timeout", timeout, 1);
    req = '0;
    step();
    check("wd_pulse_end", timeout, 0);
`else
    check("wd_hold_grant", grant, 4'b0100);
    check("wd_hold_timeout", timeout, 0);
    goto_cyc(k + 20);
    check("wd_long_grant", grant, 4'b0100);
    done = 1'b1;
    req  = '0;
    step();
    done = 1'b0;
    check("wd_end_grant", grant, 0);
    step();
`endif

    // Reset mid-transaction: pointer returns so master 0 wins next
    k   = cyc;
    req = 4'b1000;
    push_exp(3, k + 1);
    goto_cyc(k + 3);
    reset = 1'b1;
    req   = 4'b1111;
    step();
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", bus_busy, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_timeout", timeout, 0);
    reset = 1'b0;
    push_exp(0, k + 5);
    goto_cyc(k + 7);
    done = 1'b1;
    req  = '0;
    step();
    done = 1'b0;
    check("mid_rst_release", grant, 0);
    repeat (4) step();

    check("all_grants_seen", exp_q.size(), 0);
`ifdef ARB_TIMEOUT_EN
    check("timeout_count", tout_seen, 1);
`else
    check("timeout_count", tout_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
